avmm_halfword_responder: RTL
============================

// Module: avmm_halfword_responder
// PURPOSE
//  Avalon-MM pipelined-read responder: 16-bit data, waitrequest + readdatavalid.
//  Backs a halfword RAM, preloadable over the same port. Memory-side partner and
//  bench/standalone model for the func-style streaming readers, which read 32-bit
//  operands as two consecutive halfwords. Programmable latency and outstanding
//  limit, plus optional stall injection, exercise initiator waitrequest handling.
// PARAMETERS
//  MEM_WORDS        1024  halfword depth; power of 2
//  LATENCY          4     accept-to-readdatavalid cycles; >=2
//  MAX_OUTSTANDING  8     accepted-but-unreturned read limit; 1..15
//  LFSR_SEED        16'hACE1  stall-injection LFSR seed (macro only); nonzero
// PORTS
//  clk            in   1   sole clock, rising edge
//  reset          in   1   asynchronous, active-low; resets all state
//  address        in   32  byte address; bit0 ignored; idx = address[31:1] mod MEM_WORDS
//  read           in   1   read request
//  write          in   1   write request
//  writedata      in   16  write data
//  waitrequest    out  1   command not accepted this cycle
//  readdata       out  16  read data; valid only with readdatavalid
//  readdatavalid  out  1   one returned halfword per pulse, in request order
// BEHAVIOUR
//  Reset (reset=0): waitrequest=0, readdatavalid=0, readdata=0, outstanding count=0,
//   command FIFO + return pipe emptied, LFSR=LFSR_SEED. RAM not cleared.
//  Reset mid-burst: pending reads dropped, no readdatavalid after reset release.
//  Accept: read&~waitrequest or write&~waitrequest sampled at posedge.
//  read&write together: read served, write dropped (illegal; bench flags it).
//  waitrequest, combinational from registered state:
//   - outstanding==MAX_OUTSTANDING -> 1 for read and write
//   - write&(outstanding!=0) -> 1 (writes wait until all reads return; no RAW hazard)
//   - else 0 (macro: OR stall bit, below)
//  outstanding: +1 on read accept, -1 on readdatavalid; both same cycle -> unchanged.
//  Write: RAM[idx]<=writedata at the accept edge; no response.
//  Read path: accepted cmd -> cmd FIFO (depth MAX_OUTSTANDING, never overflows by
//   construction) -> server pops <=1/cycle -> 1-cycle RAM read -> delay line.
//  Server FSM:
//   - SRV_IDLE: FIFO empty; on push, pop that command and go SRV_RUN.
//   - SRV_RUN: pop 1/cycle while FIFO non-empty; empty -> SRV_IDLE.
//  Latency: unstalled, read accepted at edge t -> readdatavalid high in cycle
//   t+LATENCY; back-to-back accepts -> back-to-back returns. Stalls only add
//   delay; order always preserved.
//  readdata holds the last returned value while readdatavalid=0.
// CONFIGURATION
//  AVMM_RSP_STALL_INJECT_EN defined:
//   - 16-bit Fibonacci LFSR (taps 16,14,13,11) steps every cycle
//   - lfsr[0]=1 -> waitrequest forced 1 that cycle
//   - lfsr[1]=1 -> server pops nothing that cycle; fixed return delay then
//     >=LATENCY, data order and values unchanged
//  Undefined: no LFSR; waitrequest from outstanding/write rules only; exact latency.
// TESTING
//  1 Write 0x1111,0x2222,0x3333,0x4444 to 0x0,0x2,0x4,0x6; read all four
//    back-to-back -> readdatavalid at t+4..t+7, data 0x1111..0x4444 in order.
//  2 Func pattern: read 0x4 then 0x6 -> 0x3333 then 0x4444 (low then high half of
//    32-bit 0x44443333).
//  3 MAX_OUTSTANDING=2, LATENCY=4, hold read for 6 addresses -> waitrequest high
//    after 2 accepts, never >2 in flight, all 6 returned correct and in order.
//  4 Three reads pending, then write 0xBEEF@0x0 -> waitrequest high until third
//    readdatavalid; write accepted next cycle; read 0x0 -> 0xBEEF.
//  5 MEM_WORDS=1024: read 0x800 -> RAM[0]; read 0x801 -> RAM[0] (bit0 ignored).
//  6 Reset low 3 cycles mid 4-read burst -> no readdatavalid after release,
//    outstanding=0, waitrequest=0; RAM contents intact on readback.
//  7 Macro defined, LFSR_SEED=16'hACE1, 256 random reads -> scoreboard match,
//    waitrequest toggles, no stall when seed reloads at reset.

Source files
------------

// File: rtl/avmm_halfword_responder.sv
// Avalon-MM pipelined-read responder backed by a halfword RAM, with programmable latency and outstanding limit.
// Define AVMM_RSP_STALL_INJECT_EN to add LFSR-driven waitrequest and server-pop stalls.
module avmm_halfword_responder #(
  parameter int MEM_WORDS       = 1024,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 8
`ifdef AVMM_RSP_STALL_INJECT_EN
  , parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic        waitrequest,
  output logic [15:0] readdata,
  output logic        readdatavalid
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [3:0]    CNT_MAX  = 4'(MAX_OUTSTANDING);

  typedef enum logic {SRV_IDLE, SRV_RUN} srv_state_e;

  logic [15:0]   mem [MEM_WORDS];
  logic [AW-1:0] cmd_fifo [MAX_OUTSTANDING];

  srv_state_e    srv_q, srv_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]    fifo_cnt_q, fifo_cnt_d, out_cnt_q, out_cnt_d;
  logic [LATENCY:1] vld_q, vld_d;
  logic [15:0]   dat_q [2:LATENCY];
  logic [15:0]   dat_d [2:LATENCY];
  logic [15:0]   ram_rd_q;

  logic [AW-1:0] idx;
  logic          rd_acc, wr_acc, pop;
  logic          stall_wait, stall_pop;
  logic          unused_addr;

  assign idx         = address[AW:1];
  assign unused_addr = ^{address[31:AW+1], address[0]};

`ifdef AVMM_RSP_STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  // Gated by reset so the seed's bit 0 cannot raise waitrequest while in reset.
  assign stall_wait = reset & lfsr_q[0];
  assign stall_pop  = lfsr_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign stall_wait = 1'b0;
  assign stall_pop  = 1'b0;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    waitrequest = (out_cnt_q == CNT_MAX) | (write & (out_cnt_q != 4'd0)) | stall_wait;
    rd_acc      = read & ~waitrequest;
    wr_acc      = write & ~read & ~waitrequest;

    srv_d = srv_q;
    pop   = 1'b0;
    case (srv_q)
      SRV_IDLE: if (fifo_cnt_q != 4'd0 && !stall_pop) begin
        pop   = 1'b1;
        srv_d = SRV_RUN;
      end
      SRV_RUN: begin
        if (fifo_cnt_q == 4'd0) srv_d = SRV_IDLE;
        else                    pop   = ~stall_pop;
      end
      default: srv_d = SRV_IDLE;
    endcase

    wr_ptr_d   = rd_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop    ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + {3'b000, rd_acc} - {3'b000, pop};
    out_cnt_d  = out_cnt_q  + {3'b000, rd_acc} - {3'b000, readdatavalid};

    // Stage 1 is the RAM read register; each later stage only loads on a valid so the last one holds.
    vld_d    = {vld_q[LATENCY-1:1], pop};
    dat_d    = dat_q;
    dat_d[2] = vld_q[1] ? ram_rd_q : dat_q[2];
    for (int k = 3; k <= LATENCY; k++) dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
  end

  // NOTE: storage arrays are deliberately not reset; control state decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[idx] <= writedata;
    if (rd_acc) cmd_fifo[wr_ptr_q] <= idx;
    if (pop)    ram_rd_q <= mem[cmd_fifo[rd_ptr_q]];
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      srv_q      <= SRV_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_cnt_q  <= '0;
      vld_q      <= '0;
      for (int k = 2; k <= LATENCY; k++) dat_q[k] <= '0;
    end else begin
      srv_q      <= srv_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      out_cnt_q  <= out_cnt_d;
      vld_q      <= vld_d;
      dat_q      <= dat_d;
    end
  end

  assign readdata      = dat_q[LATENCY];
  assign readdatavalid = vld_q[LATENCY];

endmodule
